// File: rtl/fpnew_issue_rob.sv
// fpnew_issue_rob: tags FPU requests, reorders out-of-order results, retires them in issue order
module fpnew_issue_rob #(
  parameter int unsigned Width    = 64,
  parameter int unsigned ReqWidth = 128,
  parameter int unsigned NumTags  = 4,
  parameter int unsigned TagBits  = $clog2(NumTags)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ReqWidth-1:0] req_data_i,
  output logic                fpu_valid_o,
  input  logic                fpu_ready_i,
  output logic [ReqWidth-1:0] fpu_data_o,
  output logic [TagBits-1:0]  fpu_tag_o,
  output logic                fpu_flush_o,
  input  logic                fpu_out_valid_i,
  output logic                fpu_out_ready_o,
  input  logic [Width-1:0]    fpu_result_i,
  input  logic [4:0]          fpu_status_i,
  input  logic [TagBits-1:0]  fpu_tag_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [Width-1:0]    rsp_result_o,
  output logic [4:0]          rsp_status_o,
  output logic [4:0]          fflags_o,
  input  logic                fflags_clr_i,
  output logic                err_o,
  output logic                busy_o
);
  logic [TagBits:0]   wr_ptr, rd_ptr;
  logic [NumTags-1:0] alloc, done;
  logic [Width-1:0]   result_q [NumTags];
  logic [4:0]         status_q [NumTags];
  logic [TagBits-1:0] wi, ri;
  logic full, empty, res_hs, res_ok, retire;
  assign wi              = wr_ptr[TagBits-1:0];
  assign ri              = rd_ptr[TagBits-1:0];
  assign full            = (wr_ptr[TagBits] != rd_ptr[TagBits]) && (wi == ri);
  assign empty           = wr_ptr == rd_ptr;
  assign fpu_valid_o     = req_valid_i & ~full & ~flush_i;
  assign req_ready_o     = fpu_valid_o & fpu_ready_i;
  assign fpu_data_o      = req_data_i;
  assign fpu_tag_o       = wi;
  assign fpu_flush_o     = flush_i;
  assign fpu_out_ready_o = ~flush_i;
  assign res_hs          = fpu_out_valid_i & ~flush_i;
  assign res_ok          = alloc[fpu_tag_i] & ~done[fpu_tag_i];
  assign rsp_valid_o     = ~empty & done[ri];
  assign rsp_result_o    = result_q[ri];
  assign rsp_status_o    = status_q[ri];
  assign retire          = rsp_valid_o & rsp_ready_i & ~flush_i;
  assign busy_o          = ~empty;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      alloc    <= '0;
      done     <= '0;
      err_o    <= 1'b0;
      fflags_o <= '0;
    end else begin
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        alloc  <= '0;
        done   <= '0;
        err_o  <= 1'b0;
      end else begin
        if (req_ready_o) begin
          alloc[wi] <= 1'b1;
          done[wi]  <= 1'b0;
          wr_ptr    <= wr_ptr + (TagBits+1)'(1);
        end
        if (res_hs && res_ok) done[fpu_tag_i] <= 1'b1;
        if (retire) begin
          alloc[ri] <= 1'b0;
          done[ri]  <= 1'b0;
          rd_ptr    <= rd_ptr + (TagBits+1)'(1);
        end
        err_o <= res_hs & ~res_ok;
      end
      // a clear coinciding with a retire keeps only the retiring status
      if (retire) fflags_o <= (fflags_clr_i ? 5'b0 : fflags_o) | status_q[ri];
      else if (fflags_clr_i) fflags_o <= '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (res_hs && res_ok) begin
      result_q[fpu_tag_i] <= fpu_result_i;
      status_q[fpu_tag_i] <= fpu_status_i;
    end
  end
endmodule

// File: tb/tb_fpnew_issue_rob.sv
// tb_fpnew_issue_rob: directed scenario tests for the FPU issue/reorder block
module tb_fpnew_issue_rob;
  logic         clk_i = 1'b0, rst_i = 1'b0, flush_i = 1'b0;
  logic         req_valid_i = 1'b0, fpu_ready_i = 1'b1;
  logic [127:0] req_data_i = '0;
  logic         fpu_out_valid_i = 1'b0, rsp_ready_i = 1'b0, fflags_clr_i = 1'b0;
  logic [63:0]  fpu_result_i = '0;
  logic [4:0]   fpu_status_i = '0;
  logic [1:0]   fpu_tag_i = '0;
  logic         req_ready_o, fpu_valid_o, fpu_flush_o, fpu_out_ready_o;
  logic [127:0] fpu_data_o;
  logic [1:0]   fpu_tag_o;
  logic         rsp_valid_o, err_o, busy_o;
  logic [63:0]  rsp_result_o;
  logic [4:0]   rsp_status_o, fflags_o;
  int checks = 0, errors = 0;

  fpnew_issue_rob dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_data_i(req_data_i),
    .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_data_o(fpu_data_o),
    .fpu_tag_o(fpu_tag_o), .fpu_flush_o(fpu_flush_o),
    .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
    .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_status_o(rsp_status_o), .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic issue(input logic [127:0] d, output logic [1:0] tag);
    req_valid_i = 1'b1;
    req_data_i  = d;
    #1;
    tag = fpu_tag_o;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic give(input logic [1:0] tag, input logic [63:0] r, input logic [4:0] st);
    fpu_out_valid_i = 1'b1;
    fpu_tag_i       = tag;
    fpu_result_i    = r;
    fpu_status_i    = st;
    step();
    fpu_out_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] t;
    rst_i = 1'b1;
    req_valid_i = 1'b1;
    #1;
    checks++; if (fpu_valid_o !== 1'b1) begin errors++; $display("FAIL reset_fpu_valid got %b exp 1", fpu_valid_o); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready_o); end
    checks++; if ({rsp_valid_o, busy_o, err_o, fflags_o} !== 8'h00) begin errors++; $display("FAIL reset_outputs got %h exp 00", {rsp_valid_o, busy_o, err_o, fflags_o}); end
    step();
    req_valid_i = 1'b0;
    rst_i = 1'b0;
    issue(128'h1, t);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL busy_after_issue got %b exp 1", busy_o); end
    #2;
    rst_i = 1'b1;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL async_reset_busy got %b exp 0", busy_o); end
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_inorder();
    logic [1:0] t;
    do_reset();
    req_data_i = 128'hDEAD_BEEF;
    req_valid_i = 1'b1;
    #1;
    checks++; if (fpu_data_o !== 128'hDEAD_BEEF) begin errors++; $display("FAIL passthru_data got %h exp deadbeef", fpu_data_o); end
    req_valid_i = 1'b0;
    issue(128'hDEAD_BEEF, t);
    checks++; if (t !== 2'd0) begin errors++; $display("FAIL inorder_tag got %0d exp 0", t); end
    step();
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd0; fpu_result_i = 64'h3FF0_0000_0000_0000; fpu_status_i = 5'b00001;
    #1;
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL no_bypass got %b exp 0", rsp_valid_o); end
    step();
    fpu_out_valid_i = 1'b0;
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL inorder_valid got %b exp 1", rsp_valid_o); end
    checks++; if (rsp_result_o !== 64'h3FF0_0000_0000_0000) begin errors++; $display("FAIL inorder_result got %h exp 3ff0000000000000", rsp_result_o); end
    checks++; if (rsp_status_o !== 5'b00001) begin errors++; $display("FAIL inorder_status got %b exp 00001", rsp_status_o); end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    checks++; if (fflags_o !== 5'b00001) begin errors++; $display("FAIL inorder_fflags got %b exp 00001", fflags_o); end
    checks++; if ({rsp_valid_o, busy_o} !== 2'b00) begin errors++; $display("FAIL inorder_drain got %b exp 00", {rsp_valid_o, busy_o}); end
  endtask

  task automatic test_out_of_order();
    logic [1:0] t;
    logic [63:0] vals [3];
    vals[0] = 64'hA0; vals[1] = 64'hA1; vals[2] = 64'hA2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      issue(128'(i), t);
      checks++; if (t !== 2'(i)) begin errors++; $display("FAIL ooo_tag%0d got %0d exp %0d", i, t, i); end
    end
    give(2'd2, vals[2], 5'b0);
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL ooo_wait_head got %b exp 0", rsp_valid_o); end
    give(2'd0, vals[0], 5'b0);
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL ooo_head_valid got %b exp 1", rsp_valid_o); end
    give(2'd1, vals[1], 5'b0);
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== vals[i]) begin errors++; $display("FAIL ooo_retire%0d got %b/%h exp 1/%h", i, rsp_valid_o, rsp_result_o, vals[i]); end
      step();
    end
    rsp_ready_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL ooo_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_full();
    logic [1:0] t;
    do_reset();
    for (int i = 0; i < 4; i++) issue(128'(i), t);
    req_valid_i = 1'b1;
    #1;
    checks++; if (fpu_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin errors++; $display("FAIL full_block got %b%b exp 00", fpu_valid_o, req_ready_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL full_busy got %b exp 1", busy_o); end
    req_valid_i = 1'b0;
    give(2'd0, 64'h5, 5'b0);
    req_valid_i = 1'b1;
    rsp_ready_i = 1'b1;
    #1;
    checks++; if (fpu_valid_o !== 1'b0) begin errors++; $display("FAIL full_same_cycle got %b exp 0", fpu_valid_o); end
    step();
    rsp_ready_i = 1'b0;
    checks++; if (fpu_valid_o !== 1'b1 || fpu_tag_o !== 2'd0) begin errors++; $display("FAIL full_wrap got %b/%0d exp 1/0", fpu_valid_o, fpu_tag_o); end
    req_valid_i = 1'b0;
  endtask

  task automatic test_backpressure_flags();
    logic [1:0] t;
    do_reset();
    for (int i = 0; i < 3; i++) issue(128'(i), t);
    give(2'd0, 64'hB0, 5'b10000);
    give(2'd1, 64'hB1, 5'b00001);
    give(2'd2, 64'hB2, 5'b00001);
    for (int i = 0; i < 3; i++) begin
      checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 64'hB0 || rsp_status_o !== 5'b10000) begin errors++; $display("FAIL bp_stable%0d got %b/%h/%b exp 1/b0/10000", i, rsp_valid_o, rsp_result_o, rsp_status_o); end
      step();
    end
    checks++; if (fflags_o !== 5'b0) begin errors++; $display("FAIL bp_fflags_idle got %b exp 00000", fflags_o); end
    rsp_ready_i = 1'b1;
    step();
    checks++; if (fflags_o !== 5'b10000) begin errors++; $display("FAIL flags_nv got %b exp 10000", fflags_o); end
    step();
    checks++; if (fflags_o !== 5'b10001) begin errors++; $display("FAIL flags_nv_nx got %b exp 10001", fflags_o); end
    fflags_clr_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    checks++; if (fflags_o !== 5'b00001) begin errors++; $display("FAIL flags_clr_retire got %b exp 00001", fflags_o); end
    step();
    fflags_clr_i = 1'b0;
    checks++; if (fflags_o !== 5'b00000) begin errors++; $display("FAIL flags_clr_alone got %b exp 00000", fflags_o); end
  endtask

  task automatic test_flush();
    logic [1:0] t;
    do_reset();
    for (int i = 0; i < 3; i++) issue(128'(i), t);
    flush_i = 1'b1;
    req_valid_i = 1'b1;
    fpu_out_valid_i = 1'b1; fpu_tag_i = 2'd1; fpu_result_i = 64'hC1; fpu_status_i = 5'b0;
    #1;
    checks++; if (fpu_flush_o !== 1'b1 || fpu_out_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ports got %b%b exp 10", fpu_flush_o, fpu_out_ready_o); end
    checks++; if (req_ready_o !== 1'b0 || fpu_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_issue got %b%b exp 00", req_ready_o, fpu_valid_o); end
    step();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    fpu_out_valid_i = 1'b0;
    checks++; if ({err_o, busy_o, rsp_valid_o} !== 3'b000) begin errors++; $display("FAIL flush_after got %b exp 000", {err_o, busy_o, rsp_valid_o}); end
    issue(128'h9, t);
    checks++; if (t !== 2'd0) begin errors++; $display("FAIL flush_tag got %0d exp 0", t); end
  endtask

  task automatic test_spurious();
    logic [1:0] t;
    do_reset();
    issue(128'h7, t);
    give(2'd3, 64'hEE, 5'b11111);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL spur_err got %b exp 1", err_o); end
    checks++; if (busy_o !== 1'b1 || rsp_valid_o !== 1'b0) begin errors++; $display("FAIL spur_state got %b%b exp 10", busy_o, rsp_valid_o); end
    step();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL spur_err_pulse got %b exp 0", err_o); end
    give(2'd0, 64'h77, 5'b0);
    checks++; if (rsp_valid_o !== 1'b1 || rsp_result_o !== 64'h77 || err_o !== 1'b0) begin errors++; $display("FAIL spur_real got %b/%h/%b exp 1/77/0", rsp_valid_o, rsp_result_o, err_o); end
    give(2'd0, 64'h88, 5'b0);
    checks++; if (err_o !== 1'b1 || rsp_result_o !== 64'h77) begin errors++; $display("FAIL spur_dup got %b/%h exp 1/77", err_o, rsp_result_o); end
  endtask

  initial begin
    test_reset();
    test_inorder();
    test_out_of_order();
    test_full();
    test_backpressure_flags();
    test_flush();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpnew_issue_rob.md
# fpnew_issue_rob

Core-side initiator for the FPU's tagged valid/ready interface. It accepts operation requests from the core and assigns each a rotating tag. It forwards the request to the FPU and captures results, which may come back out of order across operation groups, in a reorder buffer. Results retire to the core in issue order, and the block keeps sticky accrued exception flags.

## Interface
- `Width`, 64: FP result width; matches FPU `Features.Width`.
- `ReqWidth`, 128: width of the opaque request payload (operands, op, formats, rounding mode), passed through unmodified.
- `NumTags`, 4: reorder buffer depth and maximum outstanding operations; power of two, ≥2.
- `TagBits`, `$clog2(NumTags)`: derived; do not override.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: abort all outstanding operations.
- `req_valid_i` in 1: core request valid.
- `req_ready_o` out 1: core request accepted.
- `req_data_i` in `ReqWidth`: request payload.
- `fpu_valid_o` out 1: drives FPU `in_valid_i`.
- `fpu_ready_i` in 1: from FPU `in_ready_o`; may depend combinationally on `fpu_valid_o`.
- `fpu_data_o` out `ReqWidth`: payload to FPU.
- `fpu_tag_o` out `TagBits`: drives FPU `tag_i`.
- `fpu_flush_o` out 1: drives FPU `flush_i`.
- `fpu_out_valid_i` in 1: FPU result valid.
- `fpu_out_ready_o` out 1: FPU result accept.
- `fpu_result_i` in `Width`: FPU result.
- `fpu_status_i` in 5: FPU status {NV,DZ,OF,UF,NX}.
- `fpu_tag_i` in `TagBits`: FPU result tag.
- `rsp_valid_o` out 1: in-order result valid.
- `rsp_ready_i` in 1: core accepts result.
- `rsp_result_o` out `Width`: retiring result.
- `rsp_status_o` out 5: retiring status.
- `fflags_o` out 5: sticky OR of retired status.
- `fflags_clr_i` in 1: clear `fflags_o`.
- `err_o` out 1: one-cycle pulse on a result carrying an unallocated tag.
- `busy_o` out 1: any slot allocated.

## Operation
- State: `wr_ptr` and `rd_ptr`, each `TagBits+1` wide with a wrap bit. Per slot: `alloc`, `done`, `result`, `status`.
- Full when the pointers are equal except for the wrap bit. Empty when the pointers are equal.
- Issue path is combinational pass-through:
  - `fpu_valid_o = req_valid_i & ~full & ~flush_i`
  - `req_ready_o = fpu_valid_o & fpu_ready_i`
  - `fpu_data_o = req_data_i`
  - `fpu_tag_o = wr_ptr[TagBits-1:0]`
  - `fpu_valid_o` never depends on `fpu_ready_i`.
- On issue handshake: set `alloc[wr_ptr]`, clear `done[wr_ptr]`, increment `wr_ptr` (wraps naturally).
- Result path: `fpu_out_ready_o = ~flush_i`. Every slot is pre-reserved, so results are never back-pressured.
- On result handshake:
  - If `alloc[tag] & ~done[tag]`: store result and status, set `done`.
  - Otherwise: drop the result and pulse `err_o` on the next cycle.
- Retire: `rsp_valid_o = ~empty & done[rd_ptr]`. Result and status are read from slot `rd_ptr`.
- On retire handshake: clear `alloc`/`done[rd_ptr]`, increment `rd_ptr`, and OR status into `fflags`.
- `fflags_clr_i` with a retire in the same cycle: `fflags` takes the retiring status. Clear alone: `fflags` goes to 0.
- `fflags_o` is not affected by flush.
- Full is computed from registered pointers. A retire does not free a slot for an issue in the same cycle.
- Issue and result may target the same slot in the same cycle only if the result tag is stale; the result is then dropped per the rule above.
- `flush_i`:
  - `fpu_flush_o = flush_i` (combinational).
  - Next cycle: all `alloc`/`done` cleared, both pointers 0.
  - Results arriving during the flush cycle are discarded with no `err_o`.
  - No issue or retire occurs in the flush cycle; `req_ready_o = 0` and `rsp_valid_o` is unchanged.
- `busy_o = ~empty`, registered-derived.

## Timing
- Reset values, asynchronous, taking effect immediately:
  - Pointers 0; all `alloc`/`done` 0.
  - `fflags_o` 0, `err_o` 0, `busy_o` 0, `rsp_valid_o` 0.
  - `fpu_valid_o` and `req_ready_o` follow the combinational equations; with empty state they equal `req_valid_i`.
- Issue latency 0 (combinational to FPU).
- Result accepted in cycle N → `rsp_valid_o` earliest in cycle N+1. No bypass.
- Retire throughput 1 per cycle.
- `rsp_*` outputs are stable while `rsp_valid_o & ~rsp_ready_i`.
- `err_o` rises in cycle N+1 and lasts exactly 1 cycle.
- Reset asserted mid-operation discards all state; outputs return to reset values in the same cycle.

## Test plan
- **In-order single op:** issue with tag 0; FPU returns 64'h3FF0_0000_0000_0000 with status 5'b00001 two cycles later → `rsp_valid_o` the following cycle with that value; `fflags_o` = 5'b00001 after retire.
- **Out-of-order return:** issue tags 0, 1, 2; results return in order 2, 0, 1 → retire order 0, 1, 2; `rsp_valid_o` stays low until tag 0 is done.
- **Full:** with `NumTags`=4, issue 4 ops with no results back → `fpu_valid_o` = 0 on the 5th request and `busy_o` = 1. Retire one → the next issue uses tag 0 after wrap.
- **Back-pressure and flags:** hold `rsp_ready_i` = 0 for 3 cycles → output stable. Retire NV then NX → `fflags_o` = 5'b10001. Assert `fflags_clr_i` while NX retires → 5'b00001.
- **Flush:** 3 outstanding ops, assert `flush_i` while a result is arriving → `fpu_flush_o` = 1, no `err_o`, next cycle `busy_o` = 0; the next issue uses tag 0.
- **Spurious tag:** result with tag 3 while only tag 0 is allocated → dropped, `err_o` = 1 for exactly one cycle, ROB state unchanged.
